// File: rtl/cfg_reg_pkg.sv
// Shared definitions for the configuration-register arbiter: register
// address constants, FSM state encoding and requester port identity.
package cfg_reg_pkg;

  localparam logic [7:0] ADDR_OUT_LO  = 8'h00;
  localparam logic [7:0] ADDR_OUT_HI  = 8'h01;
  localparam logic [7:0] ADDR_PWM_LO  = 8'h02;
  localparam logic [7:0] ADDR_PWM_HI  = 8'h03;
  localparam logic [7:0] ADDR_DUTY    = 8'h04;
  localparam logic [7:0] ADDR_LOCK    = 8'h05;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  typedef enum logic {
    PORT_SPI = 1'b0,
    PORT_SEQ = 1'b1
  } port_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. req_i[0] is the SPI port, req_i[1] the
// sequencer port. The preference pointer moves only when accept_i says the
// current grant was taken, so an unaccepted grant does not rotate priority.
module rr_arb2
  import cfg_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  port_id_e pref_q, pref_d;

  // Grant: a lone requester always wins; on a tie the preferred port wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (pref_q == PORT_SEQ) ? 2'b10 : 2'b01;
    end
  end

  // Next preference: the port that did not just win.
  always_comb begin
    pref_d = pref_q;
    if (accept_i && (gnt_o != 2'b00)) begin
      pref_d = gnt_o[0] ? PORT_SEQ : PORT_SPI;
    end
  end

  // Preference pointer register; SPI preferred out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pref_q <= PORT_SPI;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
      pref_q <= pref_d;
    end
  end

endmodule

// File: rtl/cfg_reg_arbiter.sv
// Configuration register bank shared by an SPI requester and an on-chip
// sequencer. An IDLE/GRANT FSM accepts one write every two cycles; the
// round-robin arbiter picks the port. Optional feature macro CFG_LOCK_EN
// adds an SPI-only lock register at 0x05 that blocks sequencer writes.
module cfg_reg_arbiter
  import cfg_reg_pkg::*;
#(
  parameter logic [7:0] DUTY_RST = 8'h00,
  parameter int         ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_wr_valid,
  input  logic [ADDR_W-1:0] spi_wr_addr,
  input  logic [7:0]        spi_wr_data,
  output logic              spi_wr_ready,
  input  logic              seq_wr_valid,
  input  logic [ADDR_W-1:0] seq_wr_addr,
  input  logic [7:0]        seq_wr_data,
  output logic              seq_wr_ready,
  output logic [7:0]        en_reg_out_7_0,
  output logic [7:0]        en_reg_out_15_8,
  output logic [7:0]        en_reg_pwm_7_0,
  output logic [7:0]        en_reg_pwm_15_8,
  output logic [7:0]        pwm_duty_cycle,
  output logic              wr_err
);

  state_e      state_q, state_d;
  port_id_e    winner_q, winner_d;
  logic [1:0]  gnt;
  logic        accept;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  we;
  logic        err_d;
  logic        wr_err_q;
  logic [7:0]  out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;
`ifdef CFG_LOCK_EN
  logic        lock_q;
  logic        lock_we;
`endif

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({seq_wr_valid, spi_wr_valid}),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  // FSM next state: IDLE takes a winner when anyone asks, GRANT lasts one cycle.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    accept   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          accept   = 1'b1;
          winner_d = gnt[1] ? PORT_SEQ : PORT_SPI;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM state and latched winner identity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      winner_q <= PORT_SPI;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
    end
  end

  assign spi_wr_ready = (state_q == ST_GRANT) && (winner_q == PORT_SPI);
  assign seq_wr_ready = (state_q == ST_GRANT) && (winner_q == PORT_SEQ);

  // Decode the winner's address during GRANT into a write enable or an error.
  always_comb begin
    wr_addr = (winner_q == PORT_SEQ) ? seq_wr_addr : spi_wr_addr;
    wr_data = (winner_q == PORT_SEQ) ? seq_wr_data : spi_wr_data;
    we      = '0;
    err_d   = 1'b0;
`ifdef CFG_LOCK_EN
    lock_we = 1'b0;
`endif
    if (state_q == ST_GRANT) begin
      case (wr_addr)
        ADDR_W'(ADDR_OUT_LO): we[0] = 1'b1;
        ADDR_W'(ADDR_OUT_HI): we[1] = 1'b1;
        ADDR_W'(ADDR_PWM_LO): we[2] = 1'b1;
        ADDR_W'(ADDR_PWM_HI): we[3] = 1'b1;
        ADDR_W'(ADDR_DUTY):   we[4] = 1'b1;
`ifdef CFG_LOCK_EN
        ADDR_W'(ADDR_LOCK): begin
          if (winner_q == PORT_SPI) lock_we = 1'b1;
          else                      err_d   = 1'b1;
        end
`endif
        default: err_d = 1'b1;
      endcase
`ifdef CFG_LOCK_EN
      // A locked bank silently refuses the sequencer but still flags it.
      if ((winner_q == PORT_SEQ) && lock_q && (we != 5'b0)) begin
        we    = '0;
        err_d = 1'b1;
      end
`endif
    end
  end

  // Register bank and error pulse, updated on the edge that ends GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_lo_q <= 8'h00;
      out_hi_q <= 8'h00;
      pwm_lo_q <= 8'h00;
      pwm_hi_q <= 8'h00;
      duty_q   <= DUTY_RST;
      wr_err_q <= 1'b0;
    end else begin
      if (we[0]) out_lo_q <= wr_data;
      if (we[1]) out_hi_q <= wr_data;
      if (we[2]) pwm_lo_q <= wr_data;
      if (we[3]) pwm_hi_q <= wr_data;
      if (we[4]) duty_q   <= wr_data;
      wr_err_q <= err_d;
    end
  end

`ifdef CFG_LOCK_EN
  // Lock bit, writable only from the SPI port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       lock_q <= 1'b0;
    else if (lock_we) lock_q <= wr_data[0];
  end
`endif

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign wr_err          = wr_err_q;

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Self-checking bench for cfg_reg_arbiter: a transaction-level model of the
// register bank is compared against the DUT every cycle, and directed tests
// pin the model with hand-computed values. Honours CFG_LOCK_EN.
module tb_cfg_reg_arbiter;

  localparam logic [7:0] DUTY_RST = 8'h3C;
  localparam int         ADDR_W   = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              spi_wr_valid = 1'b0;
  logic [ADDR_W-1:0] spi_wr_addr = '0;
  logic [7:0]        spi_wr_data = '0;
  logic              spi_wr_ready;
  logic              seq_wr_valid = 1'b0;
  logic [ADDR_W-1:0] seq_wr_addr = '0;
  logic [7:0]        seq_wr_data = '0;
  logic              seq_wr_ready;
  logic [7:0]        en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0]        pwm_duty_cycle;
  logic              wr_err;

  int total = 0;
  int bad   = 0;

  cfg_reg_arbiter #(.DUTY_RST(DUTY_RST), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .spi_wr_valid    (spi_wr_valid),
    .spi_wr_addr     (spi_wr_addr),
    .spi_wr_data     (spi_wr_data),
    .spi_wr_ready    (spi_wr_ready),
    .seq_wr_valid    (seq_wr_valid),
    .seq_wr_addr     (seq_wr_addr),
    .seq_wr_data     (seq_wr_data),
    .seq_wr_ready    (seq_wr_ready),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_err          (wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_busy: a write is being acknowledged this cycle by port m_port.
  logic [7:0] m_reg [0:4];
  bit         m_busy;
  int         m_port;
  int         m_last;   // port granted most recently; 1 after reset so SPI wins a tie
  logic       m_err;
  logic       m_lock;

  always @(posedge clk or negedge rst_n) begin
    int   idx;
    logic [7:0] d;
    bit   ok;
    if (!rst_n) begin
      m_reg[0] <= 8'h00; m_reg[1] <= 8'h00; m_reg[2] <= 8'h00; m_reg[3] <= 8'h00;
      m_reg[4] <= DUTY_RST;
      m_busy <= 1'b0; m_port <= 0; m_last <= 1; m_err <= 1'b0; m_lock <= 1'b0;
    end else if (m_busy) begin
      idx = (m_port == 1) ? int'(seq_wr_addr) : int'(spi_wr_addr);
      d   = (m_port == 1) ? seq_wr_data : spi_wr_data;
      ok  = (idx <= 4);
`ifdef CFG_LOCK_EN
      if (idx == 5 && m_port == 0) begin
        ok = 1'b1;
        m_lock <= d[0];
      end
      if (m_port == 1 && m_lock && idx <= 5) ok = 1'b0;
`endif
      if (ok && idx <= 4) m_reg[idx] <= d;
      m_err  <= !ok;
      m_busy <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (spi_wr_valid && seq_wr_valid) begin
        m_busy <= 1'b1; m_port <= 1 - m_last; m_last <= 1 - m_last;
      end else if (spi_wr_valid) begin
        m_busy <= 1'b1; m_port <= 0; m_last <= 0;
      end else if (seq_wr_valid) begin
        m_busy <= 1'b1; m_port <= 1; m_last <= 1;
      end
    end
  end

  // Compare every cycle out of reset, on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("spi_ready", spi_wr_ready, m_busy && m_port == 0);
      check("seq_ready", seq_wr_ready, m_busy && m_port == 1);
      check("one_ready", spi_wr_ready && seq_wr_ready, 0);
      check("wr_err", wr_err, m_err);
      check("out_7_0", en_reg_out_7_0, m_reg[0]);
      check("out_15_8", en_reg_out_15_8, m_reg[1]);
      check("pwm_7_0", en_reg_pwm_7_0, m_reg[2]);
      check("pwm_15_8", en_reg_pwm_15_8, m_reg[3]);
      check("duty", pwm_duty_cycle, m_reg[4]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    spi_wr_valid = 1'b0; seq_wr_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  // One write from a single port: lat is the number of falling edges after
  // the sampling edge before ready (0 = ready in the very next cycle),
  // err is wr_err in the cycle after the acknowledge.
  task automatic do_write(input int port, input logic [6:0] a, input logic [7:0] d,
                          output int lat, output logic err);
    @(posedge clk); #2;
    if (port == 1) begin seq_wr_valid = 1'b1; seq_wr_addr = a; seq_wr_data = d; end
    else           begin spi_wr_valid = 1'b1; spi_wr_addr = a; spi_wr_data = d; end
    @(posedge clk);
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((port == 1) ? seq_wr_ready : spi_wr_ready) begin lat = i; break; end
    end
    if (lat < 0) check("ready_timeout", 0, 1);
    @(posedge clk); #2;
    spi_wr_valid = 1'b0; seq_wr_valid = 1'b0;
    @(negedge clk);
    err = wr_err;
  endtask

  typedef struct { int port; logic [6:0] addr; logic [7:0] data; logic err; } vec_t;
  vec_t vecs [6] = '{
    '{0, 7'h00, 8'hA1, 1'b0},
    '{1, 7'h01, 8'hB2, 1'b0},
    '{0, 7'h03, 8'hC3, 1'b0},
    '{1, 7'h04, 8'h44, 1'b0},
    '{1, 7'h7F, 8'h99, 1'b1},
    '{0, 7'h06, 8'h12, 1'b1}
  };

  int   lat;
  logic err;
  int   order [6];
  int   ngr;
  int   exp_order [6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    // Reset values, sampled while reset is held.
    #12;
    check("rst_spi_ready", spi_wr_ready, 0);
    check("rst_seq_ready", seq_wr_ready, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_out_7_0", en_reg_out_7_0, 8'h00);
    check("rst_duty", pwm_duty_cycle, 8'h3C);
    @(posedge clk); #2 rst_n = 1'b1;

    // SPI-only write to duty: ready in the next cycle, register the one after.
    do_write(0, 7'h04, 8'h80, lat, err);
    check("duty_latency", lat, 0);
    check("duty_value", pwm_duty_cycle, 8'h80);
    check("duty_err", err, 0);

    // Directed vector table.
    foreach (vecs[k]) begin
      do_write(vecs[k].port, vecs[k].addr, vecs[k].data, lat, err);
      check("vec_latency", lat, 0);
      check("vec_err", err, vecs[k].err);
    end
    check("vec_out_7_0", en_reg_out_7_0, 8'hA1);
    check("vec_out_15_8", en_reg_out_15_8, 8'hB2);
    check("vec_pwm_15_8", en_reg_pwm_15_8, 8'hC3);
    check("vec_duty", pwm_duty_cycle, 8'h44);

    // Invalid sequencer write: one error pulse, nothing changes.
    do_write(1, 7'h07, 8'hFF, lat, err);
    check("bad_addr_err", err, 1);
    @(negedge clk);
    check("bad_addr_err_once", wr_err, 0);
    check("bad_addr_out_7_0", en_reg_out_7_0, 8'hA1);
    check("bad_addr_duty", pwm_duty_cycle, 8'h44);

    // Tie from reset: SPI first, then SEQ; SEQ's data ends up in the register.
    do_reset();
    @(posedge clk); #2;
    spi_wr_valid = 1'b1; spi_wr_addr = 7'h00; spi_wr_data = 8'h11;
    seq_wr_valid = 1'b1; seq_wr_addr = 7'h00; seq_wr_data = 8'h22;
    ngr = 0;
    for (int i = 0; i < 20 && ngr < 2; i++) begin
      @(negedge clk);
      if (spi_wr_ready || seq_wr_ready) begin
        order[ngr] = seq_wr_ready ? 1 : 0;
        ngr++;
        @(posedge clk); #2;
        if (order[ngr-1] == 0) spi_wr_valid = 1'b0; else seq_wr_valid = 1'b0;
      end
    end
    check("tie_grants", ngr, 2);
    check("tie_first", order[0], 0);
    check("tie_second", order[1], 1);
    @(negedge clk);
    check("tie_out_7_0", en_reg_out_7_0, 8'h22);

    // Both ports held: strict alternation over six grants.
    do_reset();
    @(posedge clk); #2;
    spi_wr_valid = 1'b1; spi_wr_addr = 7'h02; spi_wr_data = 8'h10;
    seq_wr_valid = 1'b1; seq_wr_addr = 7'h03; seq_wr_data = 8'h20;
    ngr = 0;
    for (int i = 0; i < 40 && ngr < 6; i++) begin
      @(negedge clk);
      if (spi_wr_ready || seq_wr_ready) begin
        order[ngr] = seq_wr_ready ? 1 : 0;
        ngr++;
      end
    end
    @(posedge clk); #2;
    spi_wr_valid = 1'b0; seq_wr_valid = 1'b0;
    check("rr_grants", ngr, 6);
    foreach (exp_order[k]) check("rr_order", order[k], exp_order[k]);
    @(negedge clk);
    check("rr_pwm_7_0", en_reg_pwm_7_0, 8'h10);
    check("rr_pwm_15_8", en_reg_pwm_15_8, 8'h20);

    // Reset during GRANT aborts the write.
    do_reset();
    @(posedge clk); #2;
    spi_wr_valid = 1'b1; spi_wr_addr = 7'h02; spi_wr_data = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_grant", spi_wr_ready, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_ready", spi_wr_ready, 0);
    @(posedge clk); #2;
    spi_wr_valid = 1'b0;
    check("abort_pwm_7_0", en_reg_pwm_7_0, 8'h00);
    check("abort_duty", pwm_duty_cycle, 8'h3C);
    check("abort_err", wr_err, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("abort_after_pwm_7_0", en_reg_pwm_7_0, 8'h00);

    // Lock register behaviour (or its absence).
    do_reset();
    do_write(0, 7'h05, 8'h01, lat, err);
`ifdef CFG_LOCK_EN
    check("lock_spi_err", err, 0);
    do_write(1, 7'h01, 8'h33, lat, err);
    check("lock_seq_err", err, 1);
    check("lock_out_15_8", en_reg_out_15_8, 8'h00);
    do_write(1, 7'h05, 8'h00, lat, err);
    check("lock_seq_lockreg_err", err, 1);
    do_write(0, 7'h01, 8'h44, lat, err);
    check("lock_spi_still_writes", en_reg_out_15_8, 8'h44);
`else
    check("nolock_spi_err", err, 1);
    do_write(1, 7'h01, 8'h33, lat, err);
    check("nolock_seq_err", err, 0);
    check("nolock_out_15_8", en_reg_out_15_8, 8'h33);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cfg_reg_arbiter.md
CFG_REG_ARBITER -- requirements
Module: cfg_reg_arbiter

Interface
REQ-001 Parameter: DUTY_RST, 8'h00, reset value of pwm_duty_cycle.
REQ-002 Parameter: ADDR_W, 7, write-address width for both requester ports.
REQ-003 clk  input  1  10 MHz system clock; sole clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 spi_wr_valid  input  1  SPI requester write request.
REQ-006 spi_wr_addr  input  ADDR_W  SPI write address.
REQ-007 spi_wr_data  input  8  SPI write data.
REQ-008 spi_wr_ready  output  1  one-cycle acknowledge to the SPI requester.
REQ-009 seq_wr_valid / seq_wr_addr / seq_wr_data / seq_wr_ready  in/in/in/out  1/ADDR_W/8/1  on-chip sequencer port, same semantics as SPI port.
REQ-010 en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle  output  8 each  register bank.
REQ-011 wr_err  output  1  one-cycle pulse when an acknowledged write was dropped.

Function
REQ-012 FSM states: IDLE, GRANT; GRANT lasts exactly one cycle, then the FSM returns to IDLE.
REQ-013 IDLE with any valid high: select a winner and move to GRANT on the next edge, latching winner identity.
REQ-014 In GRANT: assert the winner's ready for that cycle only; the register update and any wr_err pulse take effect on the edge ending GRANT.
REQ-015 Latency: valid sampled high at edge N gives ready high during cycle N+1 and the register updated at edge N+2; throughput is one write per 2 cycles.
REQ-016 Requesters hold valid/addr/data stable until ready; addr/data are sampled during GRANT.
REQ-017 A valid that drops before ready is granted anyway; the write uses the values present in GRANT.
REQ-018 Arbitration is 2-way round robin: on a tie, the port not granted last wins; after reset, SPI is treated as last-granted-none, so SPI wins the first tie.
REQ-019 A single requesting port always wins regardless of the pointer; the pointer updates only on grant.
REQ-020 Address map: 0x00 out_7_0, 0x01 out_15_8, 0x02 pwm_7_0, 0x03 pwm_15_8, 0x04 duty; all other addresses are acknowledged, have no register effect, and pulse wr_err.
REQ-021 Valid held continuously by both ports produces alternating grants SPI, SEQ, SPI, ...
REQ-022 The non-winning port's ready stays low; never both readies high.

Reset
REQ-023 rst_n low forces IDLE, both readies 0, wr_err 0, pointer to SPI-preferred, the four enable registers to 8'h00 and pwm_duty_cycle to DUTY_RST, asynchronously.
REQ-024 Reset asserted during GRANT aborts the write; no register changes.

Configuration
REQ-025 CFG_LOCK_EN defined: a lock register at address 0x05 (bit0 only, reset 0) is writable from the SPI port only; while lock=1, seq-port writes to 0x00-0x05 are acknowledged, dropped and pulse wr_err; seq writes to 0x05 always pulse wr_err.
REQ-026 CFG_LOCK_EN undefined: no lock register exists, and 0x05 is an invalid address per REQ-020.

Structure
REQ-027 Shared package cfg_reg_pkg holds the address constants (0x00-0x05), the FSM state enum and the port-ID type.
REQ-028 Arbitration is a sub-module rr_arb2 (2 requests in, one-hot grant out, pointer update on an accept strobe).

Verification
REQ-029 SPI-only write addr 0x04 data 0x80 -> spi_wr_ready is high exactly one cycle later, and pwm_duty_cycle==0x80 the following cycle.
REQ-030 Both valid from reset, SPI 0x00/0x11 and SEQ 0x00/0x22 -> SPI granted first, then SEQ; final en_reg_out_7_0==0x22.
REQ-031 Both valid held for 6 grants -> grant order is SPI, SEQ, SPI, SEQ, SPI, SEQ, with no cycle having both readies high.
REQ-032 SEQ write addr 0x07 data 0xFF -> ready and wr_err pulse once; all registers unchanged.
REQ-033 rst_n pulsed low during GRANT of a write 0x02/0x5A -> all outputs at reset values, en_reg_pwm_7_0==0x00.
REQ-034 With CFG_LOCK_EN: SPI writes 0x05/0x01, then SEQ writes 0x01/0x33 -> wr_err pulses and en_reg_out_15_8 stays 0x00; without the macro, the SPI write to 0x05 pulses wr_err.
